// File: rtl/nn_phase_sequencer_if.sv
// nn_phase_sequencer_if
// Bundles the advance/abort controls and the phase status outputs of the
// neural-network phase sequencer.
//   changes     : advance strobe from the top-level input controller
//   abort       : forces the sequencer back to IN
//   state       : current phase code (IN=000, BUFF=001, OUT=010, DONE=011)
//   layer       : index of the layer being processed
//   phase_start : one-cycle pulse on entry to BUFF or OUT
//   done        : high during the single DONE cycle
//   timeout_err : sticky dwell-watchdog error flag
// Modports:
//   master : the controller side, drives changes/abort and observes status
//   slave  : the sequencer side, observes changes/abort and drives status
interface nn_phase_sequencer_if #(
  parameter int LAYER_W = 2
);
  logic               changes;
  logic               abort;
  logic [2:0]         state;
  logic [LAYER_W-1:0] layer;
  logic               phase_start;
  logic               done;
  logic               timeout_err;

  modport master (
    output changes,
    output abort,
    input  state,
    input  layer,
    input  phase_start,
    input  done,
    input  timeout_err
  );

  modport slave (
    input  changes,
    input  abort,
    output state,
    output layer,
    output phase_start,
    output done,
    output timeout_err
  );
endinterface

// File: rtl/nn_phase_sequencer.sv
// nn_phase_sequencer
// Steps the datapath through IN -> (BUFF -> OUT) x NUM_LAYERS -> DONE -> IN.
// Each step is triggered by the changes strobe (rising edge or level,
// selected by EDGE_MODE). abort returns to IN at once; a dwell watchdog
// returns to IN and raises a sticky timeout_err when BUFF or OUT is held
// for TIMEOUT cycles without an advance. All status outputs are registered.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous, active-high
//   bus   : nn_phase_sequencer_if slave modport (changes, abort in;
//           state, layer, phase_start, done, timeout_err out)
module nn_phase_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_W    = 2,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8,
  parameter int EDGE_MODE  = 1
) (
  input logic                 clk,
  input logic                 reset,
  nn_phase_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IN   = 3'b000,
    ST_BUFF = 3'b001,
    ST_OUT  = 3'b010,
    ST_DONE = 3'b011
  } state_t;

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam bit                 WD_EN      = (TIMEOUT != 0);
  // Last count value before expiry; irrelevant when the watchdog is off.
  localparam logic [TO_W-1:0]    TO_LAST    = WD_EN ? TO_W'(TIMEOUT - 1) : '0;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LAYER_W-1:0] layer_r;
  logic [LAYER_W-1:0] layer_nxt_s;
  logic [TO_W-1:0]    wd_cnt_r;
  logic [TO_W-1:0]    wd_cnt_nxt_s;
  logic               changes_q_r;
  logic               adv_s;
  logic               in_phase_s;
  logic               wd_fire_s;
  logic               phase_start_r;
  logic               phase_start_nxt_s;
  logic               done_r;
  logic               done_nxt_s;
  logic               timeout_err_r;
  logic               timeout_err_nxt_s;

  // Advance event: rising edge of changes, or its plain level.
  always_comb begin
    adv_s = 1'b0;
    if (EDGE_MODE != 0) begin
      adv_s = bus.changes & ~changes_q_r;
    end else begin
      adv_s = bus.changes;
    end
  end

  // Next-state, layer, watchdog and registered-output decode.
  always_comb begin
    state_nxt_s       = state_r;
    layer_nxt_s       = layer_r;
    timeout_err_nxt_s = timeout_err_r;
    wd_cnt_nxt_s      = '0;
    in_phase_s        = (state_r == ST_BUFF) || (state_r == ST_OUT);
    wd_fire_s         = WD_EN && in_phase_s && (wd_cnt_r == TO_LAST);

    if (bus.abort) begin
      state_nxt_s = ST_IN;
      layer_nxt_s = '0;
    end else if (state_r == ST_DONE) begin
      // DONE lasts one cycle; any advance seen here is dropped.
      state_nxt_s = ST_IN;
      layer_nxt_s = '0;
    end else if (adv_s) begin
      case (state_r)
        ST_IN: begin
          state_nxt_s       = ST_BUFF;
          layer_nxt_s       = '0;
          timeout_err_nxt_s = 1'b0;
        end
        ST_BUFF: begin
          state_nxt_s = ST_OUT;
        end
        ST_OUT: begin
          if (layer_r == LAST_LAYER) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_BUFF;
            layer_nxt_s = layer_r + LAYER_W'(1'b1);
          end
        end
        default: begin
          state_nxt_s = ST_IN;
          layer_nxt_s = '0;
        end
      endcase
    end else if (wd_fire_s) begin
      state_nxt_s       = ST_IN;
      layer_nxt_s       = '0;
      timeout_err_nxt_s = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end

    // Dwell count restarts on every phase change and only runs in BUFF/OUT.
    if (state_nxt_s != state_r) begin
      wd_cnt_nxt_s = '0;
    end else if (WD_EN && in_phase_s) begin
      wd_cnt_nxt_s = wd_cnt_r + TO_W'(1'b1);
    end else begin
      wd_cnt_nxt_s = '0;
    end

    phase_start_nxt_s = (state_nxt_s != state_r) &&
                        ((state_nxt_s == ST_BUFF) || (state_nxt_s == ST_OUT));
    done_nxt_s        = (state_nxt_s == ST_DONE);
  end

  // State, counter, edge register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IN;
      layer_r       <= '0;
      wd_cnt_r      <= '0;
      changes_q_r   <= 1'b0;
      phase_start_r <= 1'b0;
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      layer_r       <= layer_nxt_s;
      wd_cnt_r      <= wd_cnt_nxt_s;
      changes_q_r   <= bus.changes;
      phase_start_r <= phase_start_nxt_s;
      done_r        <= done_nxt_s;
      timeout_err_r <= timeout_err_nxt_s;
    end
  end

  assign bus.state       = state_r;
  assign bus.layer       = layer_r;
  assign bus.phase_start = phase_start_r;
  assign bus.done        = done_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_nn_phase_sequencer.sv
// tb_nn_phase_sequencer
// Directed bench for nn_phase_sequencer with two instances:
//   dut_e : edge mode, NUM_LAYERS=3, TIMEOUT=255
//   dut_l : level mode, NUM_LAYERS=3, TIMEOUT=8
// Inputs change 1 time unit after a rising edge; outputs are checked at
// that same point, so each check reflects the edge that sampled the
// previously driven inputs.
module tb_nn_phase_sequencer;

  localparam logic [2:0] S_IN   = 3'b000;
  localparam logic [2:0] S_BUFF = 3'b001;
  localparam logic [2:0] S_OUT  = 3'b010;
  localparam logic [2:0] S_DONE = 3'b011;

  logic clk = 1'b0;
  logic reset_e;
  logic reset_l;
  int   n_vec = 0;
  int   n_err = 0;
  int   ps_cnt;
  int   dn_cnt;

  nn_phase_sequencer_if #(.LAYER_W(2)) bus_e ();
  nn_phase_sequencer_if #(.LAYER_W(2)) bus_l ();

  nn_phase_sequencer #(
    .NUM_LAYERS(3), .LAYER_W(2), .TIMEOUT(255), .TO_W(8), .EDGE_MODE(1)
  ) dut_e (
    .clk   (clk),
    .reset (reset_e),
    .bus   (bus_e.slave)
  );

  nn_phase_sequencer #(
    .NUM_LAYERS(3), .LAYER_W(2), .TIMEOUT(8), .TO_W(4), .EDGE_MODE(0)
  ) dut_l (
    .clk   (clk),
    .reset (reset_l),
    .bus   (bus_l.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic [2:0] st, input logic [1:0] ly,
                       input logic ps, input logic dn, input logic te);
    check({tag, ".state"}, 32'(bus_e.state), 32'(st));
    check({tag, ".layer"}, 32'(bus_e.layer), 32'(ly));
    check({tag, ".phase_start"}, 32'(bus_e.phase_start), 32'(ps));
    check({tag, ".done"}, 32'(bus_e.done), 32'(dn));
    check({tag, ".timeout_err"}, 32'(bus_e.timeout_err), 32'(te));
  endtask

  task automatic chk_l(input string tag, input logic [2:0] st, input logic [1:0] ly,
                       input logic ps, input logic dn, input logic te);
    check({tag, ".state"}, 32'(bus_l.state), 32'(st));
    check({tag, ".layer"}, 32'(bus_l.layer), 32'(ly));
    check({tag, ".phase_start"}, 32'(bus_l.phase_start), 32'(ps));
    check({tag, ".done"}, 32'(bus_l.done), 32'(dn));
    check({tag, ".timeout_err"}, 32'(bus_l.timeout_err), 32'(te));
  endtask

  task automatic pulse_e();
    bus_e.changes = 1'b1;
    tick();
    bus_e.changes = 1'b0;
    tick();
  endtask

  logic [2:0] seq_st [9];
  logic [1:0] seq_ly [9];
  logic       seq_ps [9];
  logic       seq_dn [9];

  initial begin
    reset_e = 1'b1;
    reset_l = 1'b1;
    bus_e.changes = 1'b0;
    bus_e.abort   = 1'b0;
    bus_l.changes = 1'b0;
    bus_l.abort   = 1'b0;
    tick();
    tick();
    chk_e("e_reset", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    chk_l("l_reset", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_e = 1'b0;
    reset_l = 1'b0;
    tick();
    chk_e("e_idle", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);

    // Expected phase walk for one inference (shared by both modes).
    seq_st = '{S_BUFF, S_OUT, S_BUFF, S_OUT, S_BUFF, S_OUT, S_DONE, S_IN, S_BUFF};
    seq_ly = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    seq_ps = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    seq_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Edge mode: seven isolated pulses walk a full inference.
    ps_cnt = 0;
    dn_cnt = 0;
    for (int p = 0; p < 7; p++) begin
      bus_e.changes = 1'b1;
      tick();
      chk_e($sformatf("e_pulse%0d", p), seq_st[p], seq_ly[p], seq_ps[p], seq_dn[p], 1'b0);
      ps_cnt += int'(bus_e.phase_start);
      dn_cnt += int'(bus_e.done);
      bus_e.changes = 1'b0;
      for (int j = 0; j < 3; j++) begin
        tick();
        ps_cnt += int'(bus_e.phase_start);
        dn_cnt += int'(bus_e.done);
        if (p == 6 && j == 0) begin
          chk_e("e_after_done", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
        end
      end
    end
    check("e_phase_start_pulses", 32'(ps_cnt), 32'd6);
    check("e_done_cycles", 32'(dn_cnt), 32'd1);

    // Edge mode: a level held for 10 cycles gives one advance only.
    bus_e.changes = 1'b1;
    tick();
    chk_e("e_hold_first", S_BUFF, 2'd0, 1'b1, 1'b0, 1'b0);
    ps_cnt = 0;
    for (int i = 1; i < 10; i++) begin
      tick();
      ps_cnt += int'(bus_e.phase_start);
    end
    check("e_hold_state", 32'(bus_e.state), 32'(S_BUFF));
    check("e_hold_extra_ps", 32'(ps_cnt), 32'd0);
    bus_e.changes = 1'b0;
    tick();

    // Edge mode: reach BUFF/2, then reset mid-operation with changes high.
    for (int i = 0; i < 4; i++) begin
      pulse_e();
    end
    chk_e("e_buff2", S_BUFF, 2'd2, 1'b0, 1'b0, 1'b0);
    reset_e = 1'b1;
    bus_e.changes = 1'b1;
    tick();
    chk_e("e_mid_reset", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_e = 1'b0;
    bus_e.changes = 1'b0;
    tick();
    chk_e("e_release_low", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    bus_e.changes = 1'b1;
    tick();
    chk_e("e_release_rise", S_BUFF, 2'd0, 1'b1, 1'b0, 1'b0);
    bus_e.changes = 1'b0;

    // Level mode: held high advances every cycle; DONE in 7, IN in 8, BUFF in 9.
    bus_l.changes = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      chk_l($sformatf("l_level_c%0d", c + 1), seq_st[c], seq_ly[c], seq_ps[c], seq_dn[c], 1'b0);
    end
    bus_l.changes = 1'b0;

    // Watchdog: BUFF held for exactly 8 cycles, then IN with error.
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("l_dwell%0d", i), 32'(bus_l.state), 32'(S_BUFF));
    end
    tick();
    chk_l("l_timeout", S_IN, 2'd0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_l("l_err_sticky", S_IN, 2'd0, 1'b0, 1'b0, 1'b1);
    bus_l.changes = 1'b1;
    tick();
    chk_l("l_err_clear", S_BUFF, 2'd0, 1'b1, 1'b0, 1'b0);
    bus_l.changes = 1'b0;

    // Advance on the expiry cycle wins over the watchdog.
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    bus_l.changes = 1'b1;
    tick();
    chk_l("l_adv_at_expiry", S_OUT, 2'd0, 1'b1, 1'b0, 1'b0);

    // Abort from OUT/1, then abort beating a simultaneous advance.
    tick();
    tick();
    bus_l.changes = 1'b0;
    chk_l("l_out1", S_OUT, 2'd1, 1'b1, 1'b0, 1'b0);
    bus_l.abort = 1'b1;
    tick();
    chk_l("l_abort_out1", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    bus_l.changes = 1'b1;
    tick();
    chk_l("l_abort_vs_adv", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    bus_l.abort = 1'b0;
    tick();
    bus_l.changes = 1'b0;
    chk_l("l_after_abort", S_BUFF, 2'd0, 1'b1, 1'b0, 1'b0);

    // Abort keeps timeout_err; reset clears it.
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    chk_l("l_timeout2", S_IN, 2'd0, 1'b0, 1'b0, 1'b1);
    bus_l.abort = 1'b1;
    tick();
    chk_l("l_abort_keeps_err", S_IN, 2'd0, 1'b0, 1'b0, 1'b1);
    bus_l.abort = 1'b0;
    reset_l = 1'b1;
    tick();
    chk_l("l_reset_err", S_IN, 2'd0, 1'b0, 1'b0, 1'b0);
    reset_l = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
